// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared snoop bus.
// Holds a one-hot grant until bus_done, with a watchdog that forces release.
module snoop_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               bus_done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               bus_start,
    output logic               busy,
    output logic               timeout_err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        winner, winner_n, ptr, ptr_n, ptr_adv, pick_base, pick_idx;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_REQ-1:0]   gnt_q, pick_mask;
    logic                 expire, end_txn, pick_any;

    // First set bit of m scanning b, b+1, ... with wrap.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] m,
                                              input logic [IW-1:0] b);
        logic [2*NUM_REQ-1:0] dbl;
        logic                 found;
        int                   s;
        dbl     = {m, m} >> b;
        found   = 1'b0;
        rr_pick = b;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && dbl[k]) begin
                found = 1'b1;
                s     = int'(b) + k;
                if (s >= NUM_REQ) s = s - NUM_REQ;
                rr_pick = IW'(s);
            end
        end
    endfunction

    assign expire    = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (cnt == TMAX);
    assign end_txn   = (state != IDLE) && (bus_done || expire);
    assign ptr_adv   = (winner == LAST) ? '0 : winner + 1'b1;
    // The finishing winner's bit is masked so it cannot win back-to-back.
    assign pick_mask = (state == IDLE) ? req : (req & ~gnt_q);
    assign pick_base = (state == IDLE) ? ptr : ptr_adv;
    assign pick_any  = |pick_mask;
    assign pick_idx  = rr_pick(pick_mask, pick_base);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            winner <= '0;
            ptr    <= '0;
            cnt    <= '0;
            gnt_q  <= '0;
        end else begin
            state  <= state_n;
            winner <= winner_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            gnt_q  <= (state_n != IDLE) ? (NUM_REQ'(1) << winner_n) : '0;
        end
    end

    always_comb begin
        state_n  = state;
        winner_n = winner;
        ptr_n    = ptr;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    winner_n = pick_idx;
                    state_n  = ADDR;
                    cnt_n    = '0;
                end
            end
            default: begin
                if (end_txn) begin
                    ptr_n = ptr_adv;
                    cnt_n = '0;
                    if (pick_any) begin
                        winner_n = pick_idx;
                        state_n  = ADDR;
                    end else begin
                        state_n  = IDLE;
                    end
                end else begin
                    state_n = WAIT;
                    if (cnt != TMAX) cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        gnt         = gnt_q;
        bus_start   = (state == ADDR);
        busy        = (state != IDLE);
        timeout_err = expire && !bus_done && !rst;
    end
endmodule
